// File: rtl/aes_pkg.sv
// AES shared definitions: key-length and FSM encodings, S-box / Rcon tables,
// schedule sizing helpers and the byte-level round transforms.
// State layout: byte 0 of the block sits in bits [127:120]. Bytes fill
// column-major, so column c occupies bits [127-32c -: 32].
package aes_pkg;

    localparam int unsigned AES_BLK_W     = 128;
    localparam int unsigned AES_MAX_WORDS = 60;

    typedef enum logic [1:0] {
        KEY_128  = 2'b00,
        KEY_192  = 2'b01,
        KEY_256  = 2'b10,
        KEY_RSVD = 2'b11
    } key_len_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_EXP,
        ST_READY,
        ST_ROUND,
        ST_DONE
    } aes_state_e;

    // S-box entry 0 is held in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_f(input key_len_e len);
        case (len)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_f(input key_len_e len);
        case (len)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // RCON table, indexed 1..10 as in FIPS-197.
    function automatic logic [7:0] rcon_f(input logic [5:0] idx);
        case (idx)
            6'd1:    return 8'h01;
            6'd2:    return 8'h02;
            6'd3:    return 8'h04;
            6'd4:    return 8'h08;
            6'd5:    return 8'h10;
            6'd6:    return 8'h20;
            6'd7:    return 8'h40;
            6'd8:    return 8'h80;
            6'd9:    return 8'h1b;
            6'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Entry x lives at bit offset 8*(255-x) = {~x, 3'b000}.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word_f(input logic [31:0] w);
        return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

    function automatic logic [AES_BLK_W-1:0] sub_bytes_f(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            r[8*b +: 8] = sbox_f(s[8*b +: 8]);
        end
        return r;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [AES_BLK_W-1:0] shift_rows_f(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                r[8*(15-(4*c+row)) +: 8] = s[8*(15-(4*((c+row)%4)+row)) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime_f(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [AES_BLK_W-1:0] mix_columns_f(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime_f(a0) ^ xtime_f(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime_f(a1) ^ xtime_f(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime_f(a2) ^ xtime_f(a3) ^ a3;
            r[103-32*c -: 8] = xtime_f(a0) ^ a0 ^ a1 ^ a2 ^ xtime_f(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// One FIPS-197 key-schedule step: w[i] = w[i-Nk] ^ f(w[i-1]).
// Ports:
//   w_back  w[i-Nk]
//   w_prev  w[i-1]
//   idx     word index i being produced
//   nk      key length in words (4/6/8)
//   w_new   w[i]
module aes_key_word_gen
    import aes_pkg::*;
(
    input  logic [31:0] w_back,
    input  logic [31:0] w_prev,
    input  logic [5:0]  idx,
    input  logic [3:0]  nk,
    output logic [31:0] w_new
);

    logic [5:0]  nk_w;
    logic [5:0]  rem;
    logic [5:0]  quo;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;

    assign nk_w = {2'b00, nk};
    assign rem  = idx % nk_w;
    assign quo  = idx / nk_w;

    // RotWord is folded into the S-box input so only one SubWord is built.
    always_comb begin
        sub_in  = (rem == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        sub_out = sub_word_f(sub_in);
        if (rem == '0) begin
            temp = sub_out ^ {rcon_f(quo), 24'h000000};
        end else if (nk == 4'd8 && rem == 6'd4) begin
            temp = sub_out;
        end else begin
            temp = w_prev;
        end
        w_new = w_back ^ temp;
    end

endmodule

// File: rtl/encryption_rounds.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// The final round bypasses MixColumns.
// Ports:
//   blk        round input state
//   round_key  round key for this round
//   is_final   round Nr (no MixColumns)
//   blk_next   round output state
module encryption_rounds
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] blk,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 is_final,
    output logic [AES_BLK_W-1:0] blk_next
);

    logic [AES_BLK_W-1:0] shifted;
    logic [AES_BLK_W-1:0] mixed;

    assign shifted  = shift_rows_f(sub_bytes_f(blk));
    assign mixed    = mix_columns_f(shifted);
    assign blk_next = (is_final ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_iterative_core.sv
// Iterative AES-128/192/256 encryption core. A loaded key is expanded one
// word per cycle into a 60x32 round-key store; blocks are then encrypted
// UNROLL rounds per cycle.
// Ports:
//   clk_i, reset_n_i            clock, async active-low reset
//   key_v_i/key_ready_o         key load handshake (key_len_i, key_i MSB-aligned)
//   key_valid_o                 store holds a complete schedule
//   key_err_o                   one-cycle pulse on a reserved key length
//   data_v_i/data_ready_o       plaintext handshake (data_i)
//   data_v_o/data_yumi_i        ciphertext handshake (data_o)
//   busy_o                      expanding a key or encrypting
module aes_iterative_core
    import aes_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 key_v_i,
    output logic                 key_ready_o,
    input  logic [1:0]           key_len_i,
    input  logic [255:0]         key_i,
    output logic                 key_valid_o,
    output logic                 key_err_o,
    input  logic                 data_v_i,
    output logic                 data_ready_o,
    input  logic [AES_BLK_W-1:0] data_i,
    output logic                 data_v_o,
    output logic [AES_BLK_W-1:0] data_o,
    input  logic                 data_yumi_i,
    output logic                 busy_o
);

    aes_state_e           state_q, state_d;
    logic [3:0]           nk_q, nr_q;
    logic [5:0]           widx_q;
    logic [3:0]           rnd_q;
    logic [AES_BLK_W-1:0] blk_q, data_q;
    logic                 data_v_q, key_valid_q, key_err_q;
    logic [31:0]          w_mem [AES_MAX_WORDS];

    key_len_e             key_len;
    logic                 key_acc, key_len_ok, key_load, data_acc;
    logic                 exp_last, rnd_last;
    logic [31:0]          w_new;
    logic [AES_BLK_W-1:0] rk0;
    logic [AES_BLK_W-1:0] stage [UNROLL+1];

    assign key_len    = key_len_e'(key_len_i);
    // Held low while reset is asserted so every output reads 0 during reset.
    assign key_ready_o  = reset_n_i & ((state_q == ST_IDLE) | (state_q == ST_READY));
    assign data_ready_o = (state_q == ST_READY) & ~key_v_i;
    assign busy_o       = (state_q == ST_KEY_EXP) | (state_q == ST_ROUND);
    assign key_valid_o  = key_valid_q;
    assign key_err_o    = key_err_q;
    assign data_v_o     = data_v_q;
    assign data_o       = data_q;

    assign key_acc    = key_v_i & key_ready_o;
    assign key_len_ok = (key_len != KEY_RSVD);
    assign key_load   = key_acc & key_len_ok;
    assign data_acc   = data_v_i & data_ready_o;
    assign exp_last   = (widx_q == {nr_q, 2'b11});
    assign rnd_last   = ((rnd_q + 4'(UNROLL - 1)) == nr_q);

    aes_key_word_gen u_key_word_gen (
        .w_back (w_mem[widx_q - 6'(nk_q)]),
        .w_prev (w_mem[widx_q - 6'd1]),
        .idx    (widx_q),
        .nk     (nk_q),
        .w_new  (w_new)
    );

    assign rk0      = {w_mem[0], w_mem[1], w_mem[2], w_mem[3]};
    assign stage[0] = blk_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [3:0]           rk_idx;
        logic [5:0]           base;
        logic [AES_BLK_W-1:0] rk;
        assign rk_idx = rnd_q + 4'(u);
        assign base   = {rk_idx, 2'b00};
        assign rk     = {w_mem[base], w_mem[base + 6'd1], w_mem[base + 6'd2], w_mem[base + 6'd3]};
        encryption_rounds u_round (
            .blk       (stage[u]),
            .round_key (rk),
            .is_final  (rk_idx == nr_q),
            .blk_next  (stage[u+1])
        );
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (key_load) state_d = ST_KEY_EXP;
            ST_KEY_EXP: if (exp_last) state_d = ST_READY;
            ST_READY: begin
                if (key_load)      state_d = ST_KEY_EXP;
                else if (data_acc) state_d = ST_ROUND;
            end
            ST_ROUND:   if (rnd_last) state_d = ST_DONE;
            ST_DONE:    if (data_yumi_i) state_d = ST_READY;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            nk_q        <= 4'd4;
            nr_q        <= 4'd10;
            widx_q      <= '0;
            rnd_q       <= '0;
            blk_q       <= '0;
            data_q      <= '0;
            data_v_q    <= 1'b0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            key_err_q <= key_acc & ~key_len_ok;

            if (key_load) begin
                nk_q        <= nk_f(key_len);
                nr_q        <= nr_f(key_len);
                widx_q      <= {2'b00, nk_f(key_len)};
                key_valid_q <= 1'b0;
            end else if (state_q == ST_KEY_EXP) begin
                widx_q <= widx_q + 6'd1;
                if (exp_last) key_valid_q <= 1'b1;
            end

            // rnd_q is frozen on the last round so round-key reads stay inside the store.
            if (data_acc) begin
                blk_q <= data_i ^ rk0;
                rnd_q <= 4'd1;
            end else if (state_q == ST_ROUND) begin
                blk_q <= stage[UNROLL];
                if (rnd_last) begin
                    data_q   <= stage[UNROLL];
                    data_v_q <= 1'b1;
                end else begin
                    rnd_q <= rnd_q + 4'(UNROLL);
                end
            end

            if (state_q == ST_DONE && data_yumi_i) data_v_q <= 1'b0;
        end
    end

    // Key load writes all eight leading words; the surplus ones for shorter
    // keys are overwritten by expansion before they are ever read.
    always_ff @(posedge clk_i) begin
        if (key_load) begin
            for (int unsigned j = 0; j < 8; j++) begin
                w_mem[j] <= key_i[255 - 32*j -: 32];
            end
        end else if (state_q == ST_KEY_EXP) begin
            w_mem[widx_q] <= w_new;
        end
    end

endmodule

// File: tb/tb_aes_iterative_core.sv
module tb_aes_iterative_core;

    localparam logic [255:0] K128  = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] K192  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic         key_v, key_ready, key_valid, key_err, data_v, data_ready;
    logic         data_v_out, data_yumi, busy;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [127:0] data, data_out;

    logic         key2_v, key2_ready, key2_valid, key2_err, data2_v, data2_ready;
    logic         data2_v_out, data2_yumi, busy2;
    logic [1:0]   key2_len;
    logic [255:0] key2;
    logic [127:0] data2, data2_out;

    int n_checks = 0;
    int n_fail   = 0;

    aes_iterative_core #(.UNROLL(1)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .key_v_i(key_v), .key_ready_o(key_ready), .key_len_i(key_len), .key_i(key),
        .key_valid_o(key_valid), .key_err_o(key_err),
        .data_v_i(data_v), .data_ready_o(data_ready), .data_i(data),
        .data_v_o(data_v_out), .data_o(data_out), .data_yumi_i(data_yumi),
        .busy_o(busy)
    );

    aes_iterative_core #(.UNROLL(2)) dut2 (
        .clk_i(clk), .reset_n_i(reset_n),
        .key_v_i(key2_v), .key_ready_o(key2_ready), .key_len_i(key2_len), .key_i(key2),
        .key_valid_o(key2_valid), .key_err_o(key2_err),
        .data_v_i(data2_v), .data_ready_o(data2_ready), .data_i(data2),
        .data_v_o(data2_v_out), .data_o(data2_out), .data_yumi_i(data2_yumi),
        .busy_o(busy2)
    );

    // Present a key for one cycle, then count the cycles spent expanding.
    task automatic load_key(input logic [1:0] len, input logic [255:0] k, output int cycles);
        key_v = 1'b1; key_len = len; key = k;
        @(posedge clk); #1;
        key_v = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    // Present a block for one cycle; lat is the cycle index (accept cycle = 0)
    // at which data_v_o is first seen.
    task automatic run_block(input logic [127:0] pt, output logic [127:0] ct, output int lat);
        data_v = 1'b1; data = pt;
        @(posedge clk); #1;
        data_v = 1'b0;
        lat = 1;
        while (data_v_out !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        ct = data_out;
    endtask

    task automatic take_output();
        data_yumi = 1'b1;
        @(posedge clk); #1;
        data_yumi = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (key_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_key_ready: got %b expected 0", key_ready); end
        n_checks++; if (key_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        n_checks++; if (key_err !== 1'b0)    begin n_fail++; $display("FAIL reset_key_err: got %b expected 0", key_err); end
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
        n_checks++; if (data_v_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_v: got %b expected 0", data_v_out); end
        n_checks++; if (data_out !== '0)     begin n_fail++; $display("FAIL reset_data_o: got %h expected 0", data_out); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (key_ready !== 1'b1)  begin n_fail++; $display("FAIL idle_key_ready: got %b expected 1", key_ready); end
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL idle_data_ready: got %b expected 0", data_ready); end
        n_checks++; if (key2_ready !== 1'b1) begin n_fail++; $display("FAIL idle_key2_ready: got %b expected 1", key2_ready); end
    endtask

    task automatic test_key_len(input string name, input logic [1:0] len, input logic [255:0] k,
                                input int exp_cycles, input int exp_lat, input logic [127:0] exp_ct);
        int cycles, lat;
        logic [127:0] ct;
        load_key(len, k, cycles);
        n_checks++; if (cycles != exp_cycles) begin n_fail++; $display("FAIL %s_expand_cycles: got %0d expected %0d", name, cycles, exp_cycles); end
        n_checks++; if (key_valid !== 1'b1)   begin n_fail++; $display("FAIL %s_key_valid: got %b expected 1", name, key_valid); end
        n_checks++; if (data_ready !== 1'b1)  begin n_fail++; $display("FAIL %s_data_ready: got %b expected 1", name, data_ready); end
        run_block(PT, ct, lat);
        n_checks++; if (lat != exp_lat)       begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        n_checks++; if (ct !== exp_ct)        begin n_fail++; $display("FAIL %s_ct: got %h expected %h", name, ct, exp_ct); end
        take_output();
        n_checks++; if (data_v_out !== 1'b0)  begin n_fail++; $display("FAIL %s_yumi_clears: got %b expected 0", name, data_v_out); end
        n_checks++; if (data_ready !== 1'b1)  begin n_fail++; $display("FAIL %s_ready_after_yumi: got %b expected 1", name, data_ready); end
    endtask

    task automatic test_unroll2();
        int cycles, lat;
        key2_v = 1'b1; key2_len = 2'b10; key2 = K256;
        @(posedge clk); #1;
        key2_v = 1'b0;
        cycles = 0;
        while (busy2 === 1'b1 && cycles < 200) begin cycles++; @(posedge clk); #1; end
        n_checks++; if (cycles != 52)         begin n_fail++; $display("FAIL u2_expand_cycles: got %0d expected 52", cycles); end
        n_checks++; if (key2_valid !== 1'b1)  begin n_fail++; $display("FAIL u2_key_valid: got %b expected 1", key2_valid); end
        data2_v = 1'b1; data2 = PT;
        @(posedge clk); #1;
        data2_v = 1'b0;
        lat = 1;
        while (data2_v_out !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != 8)             begin n_fail++; $display("FAIL u2_latency: got %0d expected 8", lat); end
        n_checks++; if (data2_out !== CT256)  begin n_fail++; $display("FAIL u2_ct: got %h expected %h", data2_out, CT256); end
        data2_yumi = 1'b1;
        @(posedge clk); #1;
        data2_yumi = 1'b0;
        n_checks++; if (data2_v_out !== 1'b0) begin n_fail++; $display("FAIL u2_yumi_clears: got %b expected 0", data2_v_out); end
    endtask

    task automatic test_back_to_back();
        int cycles, lat;
        logic [127:0] ct;
        load_key(2'b00, K128, cycles);
        run_block(PT, ct, lat);
        n_checks++; if (ct !== CT128) begin n_fail++; $display("FAIL bp_ct: got %h expected %h", ct, CT128); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (data_out !== CT128)  begin n_fail++; $display("FAIL bp_hold_data_o[%0d]: got %h expected %h", i, data_out, CT128); end
            n_checks++; if (data_v_out !== 1'b1) begin n_fail++; $display("FAIL bp_hold_data_v[%0d]: got %b expected 1", i, data_v_out); end
            n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, data_ready); end
        end
        take_output();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, data_ready); end
            run_block(PT, ct, lat);
            n_checks++; if (ct !== CT128)        begin n_fail++; $display("FAIL b2b_ct[%0d]: got %h expected %h", i, ct, CT128); end
            n_checks++; if (lat != 11)           begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected 11", i, lat); end
            take_output();
        end
    endtask

    task automatic test_priority();
        int cycles, lat;
        logic [127:0] ct;
        key_v = 1'b1; key_len = 2'b01; key = K192;
        data_v = 1'b1; data = PT;
        #1;
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL prio_data_ready: got %b expected 0", data_ready); end
        n_checks++; if (key_ready !== 1'b1)  begin n_fail++; $display("FAIL prio_key_ready: got %b expected 1", key_ready); end
        @(posedge clk); #1;
        key_v = 1'b0; data_v = 1'b0;
        n_checks++; if (key_valid !== 1'b0)  begin n_fail++; $display("FAIL prio_key_valid_drop: got %b expected 0", key_valid); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            n_checks++; if (data_v_out !== 1'b0) begin n_fail++; $display("FAIL prio_no_block: got %b expected 0", data_v_out); end
            cycles++;
            @(posedge clk); #1;
        end
        n_checks++; if (cycles != 46)        begin n_fail++; $display("FAIL prio_expand_cycles: got %0d expected 46", cycles); end
        run_block(PT, ct, lat);
        n_checks++; if (ct !== CT192)        begin n_fail++; $display("FAIL prio_ct: got %h expected %h", ct, CT192); end
        take_output();
    endtask

    task automatic test_key_err();
        int lat;
        logic [127:0] ct;
        key_v = 1'b1; key_len = 2'b11; key = K256;
        @(posedge clk); #1;
        key_v = 1'b0;
        n_checks++; if (key_err !== 1'b1)   begin n_fail++; $display("FAIL err_pulse: got %b expected 1", key_err); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL err_key_valid: got %b expected 1", key_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL err_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (key_err !== 1'b0)   begin n_fail++; $display("FAIL err_pulse_end: got %b expected 0", key_err); end
        run_block(PT, ct, lat);
        n_checks++; if (ct !== CT192)       begin n_fail++; $display("FAIL err_old_key_ct: got %h expected %h", ct, CT192); end
        take_output();
    endtask

    task automatic test_async_reset();
        int cycles, lat;
        logic [127:0] ct;
        load_key(2'b00, K128, cycles);
        data_v = 1'b1; data = PT;
        @(posedge clk); #1;
        data_v = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (key_ready !== 1'b0)  begin n_fail++; $display("FAIL arst_key_ready: got %b expected 0", key_ready); end
        n_checks++; if (key_valid !== 1'b0)  begin n_fail++; $display("FAIL arst_key_valid: got %b expected 0", key_valid); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
        n_checks++; if (data_v_out !== 1'b0) begin n_fail++; $display("FAIL arst_data_v: got %b expected 0", data_v_out); end
        n_checks++; if (data_out !== '0)     begin n_fail++; $display("FAIL arst_data_o: got %h expected 0", data_out); end
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL arst_data_ready: got %b expected 0", data_ready); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (key_ready !== 1'b1)  begin n_fail++; $display("FAIL arst_idle_key_ready: got %b expected 1", key_ready); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL arst_idle_busy: got %b expected 0", busy); end
        load_key(2'b00, K128, cycles);
        n_checks++; if (cycles != 40)        begin n_fail++; $display("FAIL arst_expand_cycles: got %0d expected 40", cycles); end
        run_block(PT, ct, lat);
        n_checks++; if (ct !== CT128)        begin n_fail++; $display("FAIL arst_ct: got %h expected %h", ct, CT128); end
        take_output();
    endtask

    initial begin
        reset_n = 1'b0;
        key_v = 1'b0; key_len = 2'b00; key = '0; data_v = 1'b0; data = '0; data_yumi = 1'b0;
        key2_v = 1'b0; key2_len = 2'b00; key2 = '0; data2_v = 1'b0; data2 = '0; data2_yumi = 1'b0;
        test_reset();
        test_key_len("aes128", 2'b00, K128, 40, 11, CT128);
        test_key_len("aes192", 2'b01, K192, 46, 13, CT192);
        test_key_len("aes256", 2'b10, K256, 52, 15, CT256);
        test_unroll2();
        test_back_to_back();
        test_priority();
        test_key_err();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
